// File: rtl/boreal_pkg.sv
// Shared constants and types for the ADS1299 daisy-chain responder emulator.
package boreal_pkg;

  localparam int FRAME_BITS = 792;
  localparam int WORD_BITS  = 24;
  localparam int N_WORDS    = 33;
  localparam logic [3:0] STATUS_HDR = 4'hC;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_EXT   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_READING = 2'd2
  } drdy_state_e;

  function automatic logic [WORD_BITS-1:0] checker_word(input logic [7:0] ch);
    return ch[0] ? 24'hA5A5A5 : 24'h5A5A5A;
  endfunction

endpackage

// File: rtl/boreal_frame_gen.sv
// Combinational 792-bit frame builder: status word followed by 32 channel words.
module boreal_frame_gen
  import boreal_pkg::*;
(
  input  logic [1:0]            mode,
  input  logic [15:0]           seq,
  input  logic [FRAME_BITS-1:0] frame_in,
  output logic [FRAME_BITS-1:0] frame
);

  // Mode 3 is not decoded on purpose and falls through to the ramp pattern.
  always_comb begin
    frame = '0;
    case (mode_e'(mode))
      MODE_EXT: begin
        frame = frame_in;
      end
      MODE_CHECK: begin
        frame[FRAME_BITS-1 -: WORD_BITS] = {STATUS_HDR, 4'h0, seq};
        for (int k = 1; k < N_WORDS; k++) begin
          frame[FRAME_BITS-1-k*WORD_BITS -: WORD_BITS] = checker_word(k[7:0]);
        end
      end
      default: begin
        frame[FRAME_BITS-1 -: WORD_BITS] = {STATUS_HDR, 4'h0, seq};
        for (int k = 1; k < N_WORDS; k++) begin
          frame[FRAME_BITS-1-k*WORD_BITS -: WORD_BITS] = {k[7:0], seq};
        end
      end
    endcase
  end

endmodule

// File: rtl/boreal_ads_chain_emu.sv
// ADS1299 daisy-chain responder: periodic frame tick, DRDY strobe and SPI slave shifter.
module boreal_ads_chain_emu
  import boreal_pkg::*;
#(
  parameter int DRDY_PERIOD = 2000,
  parameter int DRDY_HOLD   = 400
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [FRAME_BITS-1:0] frame_in,
  input  logic                  sclk,
  input  logic                  cs_n,
  output logic                  drdy_n,
  output logic                  miso,
  output logic [15:0]           frame_count,
  output logic [7:0]            overrun_count,
  output logic [7:0]            short_count
);

  localparam int TIMER_W = $clog2(DRDY_PERIOD);
  localparam int HOLD_W  = $clog2(DRDY_HOLD + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DRDY_PERIOD - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(DRDY_HOLD - 1);
  localparam logic [9:0]         BITS_FULL  = 10'(FRAME_BITS);

  logic [TIMER_W-1:0]    timer_r;
  logic [HOLD_W-1:0]     hold_r;
  drdy_state_e           state_r, state_s;
  logic [FRAME_BITS-1:0] shift_reg_r;
  logic [FRAME_BITS-1:0] frame_s;
  logic [9:0]            bits_sent_r;
  logic                  active_r;
  logic                  cs_d_r;
  logic                  drdy_n_r;
  logic                  miso_r;
  logic [15:0]           frame_count_r;
  logic [7:0]            overrun_count_r;
  logic [7:0]            short_count_r;

  logic tick_s, load_s, shift_s, cs_fall_s, cs_rise_s;

  // A tick that lands while cs_n is low (including the cs_n fall cycle) is an overrun.
  assign tick_s    = en && (timer_r == TIMER_LAST);
  assign load_s    = tick_s && cs_n;
  assign shift_s   = !cs_n && sclk;
  assign cs_fall_s = cs_d_r && !cs_n;
  assign cs_rise_s = !cs_d_r && cs_n;

  boreal_frame_gen u_frame_gen (
    .mode     (mode),
    .seq      (frame_count_r),
    .frame_in (frame_in),
    .frame    (frame_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= '0;
    end else if (en) begin
      timer_r <= (timer_r == TIMER_LAST) ? '0 : timer_r + TIMER_W'(1);
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_s) state_s = ST_PENDING;
        else        state_s = ST_IDLE;
      end
      ST_PENDING: begin
        if (load_s)                 state_s = ST_PENDING;
        else if (shift_s)           state_s = ST_READING;
        else if (hold_r == HOLD_LAST) state_s = ST_IDLE;
        else                        state_s = ST_PENDING;
      end
      ST_READING: begin
        if (load_s)         state_s = ST_PENDING;
        else if (cs_rise_s) state_s = ST_IDLE;
        else                state_s = ST_READING;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      hold_r   <= '0;
      drdy_n_r <= 1'b1;
    end else begin
      state_r  <= state_s;
      drdy_n_r <= (state_s != ST_PENDING);
      if (load_s)                    hold_r <= '0;
      else if (state_r == ST_PENDING) hold_r <= hold_r + HOLD_W'(1);
    end
  end

  // Zeros shift in behind the frame, so over-reads return 0 without extra logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg_r   <= '0;
      miso_r        <= 1'b0;
      bits_sent_r   <= '0;
      frame_count_r <= '0;
    end else if (load_s) begin
      shift_reg_r   <= frame_s;
      miso_r        <= frame_s[FRAME_BITS-1];
      bits_sent_r   <= '0;
      frame_count_r <= frame_count_r + 16'd1;
    end else if (shift_s) begin
      shift_reg_r <= shift_reg_r << 1;
      miso_r      <= shift_reg_r[FRAME_BITS-2];
      if (bits_sent_r != BITS_FULL) bits_sent_r <= bits_sent_r + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_d_r          <= 1'b1;
      active_r        <= 1'b0;
      overrun_count_r <= '0;
      short_count_r   <= '0;
    end else begin
      cs_d_r <= cs_n;
      if (cs_fall_s)      active_r <= 1'b1;
      else if (cs_rise_s) active_r <= 1'b0;
      if (tick_s && !cs_n && overrun_count_r != 8'hFF)
        overrun_count_r <= overrun_count_r + 8'd1;
      if (cs_rise_s && active_r && bits_sent_r != 10'd0 &&
          bits_sent_r != BITS_FULL && short_count_r != 8'hFF)
        short_count_r <= short_count_r + 8'd1;
    end
  end

  assign drdy_n        = drdy_n_r;
  assign miso          = miso_r;
  assign frame_count   = frame_count_r;
  assign overrun_count = overrun_count_r;
  assign short_count   = short_count_r;

endmodule

// File: tb/tb_boreal_ads_chain_emu.sv
// Directed bench for boreal_ads_chain_emu; the bench plays the SPI chain master.
module tb_boreal_ads_chain_emu;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [791:0] frame_in;
  logic         sclk;
  logic         cs_n;
  logic         drdy_n;
  logic         miso;
  logic [15:0]  frame_count;
  logic [7:0]   overrun_count;
  logic [7:0]   short_count;

  int vectors;
  int miscompares;

  boreal_ads_chain_emu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .mode          (mode),
    .frame_in      (frame_in),
    .sclk          (sclk),
    .cs_n          (cs_n),
    .drdy_n        (drdy_n),
    .miso          (miso),
    .frame_count   (frame_count),
    .overrun_count (overrun_count),
    .short_count   (short_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Master read: sample miso in the sclk-low cycle, then pulse sclk for one clk.
  task automatic read_bits(input int n, output logic [791:0] data);
    data = '0;
    cs_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data[791-i] = miso;
      sclk = 1'b1;
      @(negedge clk);
      sclk = 1'b0;
    end
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drdy_fall(input string name, input int max_cycles);
    int n;
    n = 0;
    while (drdy_n !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (drdy_n !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: drdy_n never fell within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; sclk = 1'b0; cs_n = 1'b1; frame_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (drdy_n !== 1'b1) begin miscompares++; $display("FAIL reset_drdy: got %b expected 1", drdy_n); end
    vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b expected 0", miso); end
    vectors++; if ({frame_count, overrun_count, short_count} !== 32'd0) begin miscompares++;
      $display("FAIL reset_counters: got %h/%h/%h expected 0/0/0", frame_count, overrun_count, short_count); end
  endtask

  task automatic test_ramp_frame();
    logic [791:0] d;
    en = 1'b1; mode = 2'd0;
    repeat (1999) @(negedge clk);
    vectors++; if (drdy_n !== 1'b1) begin miscompares++; $display("FAIL ramp_drdy_early: got %b expected 1", drdy_n); end
    @(negedge clk);
    vectors++; if (drdy_n !== 1'b0) begin miscompares++; $display("FAIL ramp_drdy_2000: got %b expected 0", drdy_n); end
    vectors++; if (frame_count !== 16'd1) begin miscompares++; $display("FAIL ramp_frame_count: got %0d expected 1", frame_count); end
    read_bits(792, d);
    vectors++; if (d[791:768] !== 24'hC00000) begin miscompares++; $display("FAIL ramp_status: got %h expected c00000", d[791:768]); end
    vectors++; if (d[767:744] !== 24'h010000) begin miscompares++; $display("FAIL ramp_ch1: got %h expected 010000", d[767:744]); end
    vectors++; if (d[23:0] !== 24'h200000) begin miscompares++; $display("FAIL ramp_ch32: got %h expected 200000", d[23:0]); end
    vectors++; if (drdy_n !== 1'b1) begin miscompares++; $display("FAIL ramp_drdy_release: got %b expected 1", drdy_n); end
    vectors++; if (short_count !== 8'd0) begin miscompares++; $display("FAIL ramp_short: got %0d expected 0", short_count); end
  endtask

  task automatic test_checker_frame();
    logic [791:0] d;
    mode = 2'd1;
    wait_drdy_fall("checker_wait", 2100);
    read_bits(792, d);
    vectors++; if (d[791:768] !== 24'hC00001) begin miscompares++; $display("FAIL check_status: got %h expected c00001", d[791:768]); end
    vectors++; if (d[767:744] !== 24'hA5A5A5) begin miscompares++; $display("FAIL check_ch1: got %h expected a5a5a5", d[767:744]); end
    vectors++; if (d[743:720] !== 24'h5A5A5A) begin miscompares++; $display("FAIL check_ch2: got %h expected 5a5a5a", d[743:720]); end
    vectors++; if (frame_count !== 16'd2) begin miscompares++; $display("FAIL check_frame_count: got %0d expected 2", frame_count); end
  endtask

  task automatic test_hold();
    int low_len;
    apply_reset();
    en = 1'b1;
    for (int t = 0; t < 2; t++) begin
      wait_drdy_fall("hold_wait", 2100);
      low_len = 1;
      while (low_len < 1000) begin
        @(negedge clk);
        if (drdy_n !== 1'b0) break;
        low_len++;
      end
      vectors++; if (low_len !== 400) begin miscompares++; $display("FAIL hold_len%0d: got %0d expected 400", t, low_len); end
    end
    vectors++; if (frame_count !== 16'd2) begin miscompares++; $display("FAIL hold_frame_count: got %0d expected 2", frame_count); end
    vectors++; if (overrun_count !== 8'd0) begin miscompares++; $display("FAIL hold_overrun: got %0d expected 0", overrun_count); end
  endtask

  task automatic test_overrun();
    logic [791:0] d;
    logic saw_low;
    saw_low = 1'b0;
    cs_n = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (drdy_n === 1'b0) saw_low = 1'b1;
      if (overrun_count !== 8'd0) break;
    end
    vectors++; if (overrun_count !== 8'd1) begin miscompares++; $display("FAIL overrun_count: got %0d expected 1", overrun_count); end
    vectors++; if (saw_low !== 1'b0) begin miscompares++; $display("FAIL overrun_drdy: got pulse %b expected 0", saw_low); end
    vectors++; if (frame_count !== 16'd2) begin miscompares++; $display("FAIL overrun_frame_count: got %0d expected 2", frame_count); end
    vectors++; if (miso !== 1'b1) begin miscompares++; $display("FAIL overrun_miso: got %b expected 1", miso); end
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (short_count !== 8'd0) begin miscompares++; $display("FAIL overrun_no_short: got %0d expected 0", short_count); end
    read_bits(792, d);
    vectors++; if (d[791:768] !== 24'hC00001) begin miscompares++; $display("FAIL overrun_kept_frame: got %h expected c00001", d[791:768]); end
    vectors++; if (short_count !== 8'd0) begin miscompares++; $display("FAIL overrun_full_read: got %0d expected 0", short_count); end
  endtask

  task automatic test_short_read();
    logic [791:0] d;
    wait_drdy_fall("short_wait", 2100);
    read_bits(100, d);
    vectors++; if (d[791:768] !== 24'hC00002) begin miscompares++; $display("FAIL short_status: got %h expected c00002", d[791:768]); end
    vectors++; if (d[767:744] !== 24'h010002) begin miscompares++; $display("FAIL short_ch1: got %h expected 010002", d[767:744]); end
    vectors++; if (short_count !== 8'd1) begin miscompares++; $display("FAIL short_count: got %0d expected 1", short_count); end
    read_bits(792, d);
    vectors++; if (d[99:0] !== 100'd0) begin miscompares++; $display("FAIL overread_tail: got %h expected 0", d[99:0]); end
    vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL overread_miso: got %b expected 0", miso); end
    vectors++; if (short_count !== 8'd1) begin miscompares++; $display("FAIL overread_short: got %0d expected 1", short_count); end
    wait_drdy_fall("reload_wait", 2100);
    read_bits(792, d);
    vectors++; if (d[791:768] !== 24'hC00003) begin miscompares++; $display("FAIL reload_status: got %h expected c00003", d[791:768]); end
    vectors++; if (d[23:0] !== 24'h200003) begin miscompares++; $display("FAIL reload_ch32: got %h expected 200003", d[23:0]); end
  endtask

  task automatic test_external_and_reset();
    logic [791:0] d;
    logic [791:0] exp_ext;
    exp_ext = 792'h1;
    mode = 2'd2;
    frame_in = exp_ext;
    wait_drdy_fall("ext_wait", 2100);
    read_bits(792, d);
    vectors++; if (d !== exp_ext) begin miscompares++; $display("FAIL ext_frame: got %h expected 1", d); end
    vectors++; if (frame_count !== 16'd5) begin miscompares++; $display("FAIL ext_frame_count: got %0d expected 5", frame_count); end
    mode = 2'd0;
    wait_drdy_fall("rst_wait", 2100);
    cs_n = 1'b0;
    @(negedge clk);
    vectors++; if ({drdy_n, miso} !== 2'b01) begin miscompares++; $display("FAIL prerst_state: got drdy_n=%b miso=%b expected 0/1", drdy_n, miso); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({drdy_n, miso} !== 2'b10) begin miscompares++; $display("FAIL rst_outputs: got drdy_n=%b miso=%b expected 1/0", drdy_n, miso); end
    vectors++; if ({frame_count, overrun_count, short_count} !== 32'd0) begin miscompares++;
      $display("FAIL rst_counters: got %h/%h/%h expected 0/0/0", frame_count, overrun_count, short_count); end
    @(negedge clk);
    rst_n = 1'b1;
    cs_n = 1'b1;
    en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; frame_in = '0; sclk = 1'b0; cs_n = 1'b1;
    test_reset();
    test_ramp_frame();
    test_checker_frame();
    test_hold();
    test_overrun();
    test_short_read();
    test_external_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
